// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Prescaler width: covers speed settings 0..3 (divide by 1, 2, 4, 8).
  localparam int PRESC_W = 3;

endpackage

// File: rtl/led_seq_tickgen.sv
// Time base: free-running base counter, step prescaler and heartbeat LED.
// Latency: step_en is combinational from the counter registers (asserted in the last cycle of a period).
// Backpressure: none; the counter never stalls for pause, load or mode changes.
// Ports: clk, reset (sync, active-high), speed (step every 2^speed base periods),
//        step_en (one-cycle step request), led (high for first half of each base period).
module led_seq_tickgen
  import led_seq_pkg::*;
#(
  parameter int F_CLK_HZ = 25_000_000,
  parameter int STEP_MS  = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  output logic       step_en,
  output logic       led
);

  localparam int TICKS = (F_CLK_HZ / 1000) * STEP_MS;
  localparam int CNT_W = $clog2(TICKS);

  logic [CNT_W-1:0]   count;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] mask;
  logic               base_tick;

  assign base_tick = (count == CNT_W'(TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      presc <= '0;
    end else if (base_tick) begin
      count <= '0;
      presc <= presc + PRESC_W'(1);
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  // mask = 2^speed - 1; for speed = 3 the shift wraps to 0 and the
  // subtraction yields all ones, which is the intended divide-by-8 mask.
  assign mask    = (PRESC_W'(1) << speed) - PRESC_W'(1);
  assign step_en = base_tick && ((presc & mask) == mask);
  assign led     = (count < CNT_W'(TICKS / 2));

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate, bounce, bar-fill and hold with parallel load.
// Latency: q/tick update one clk after the step request; pause/dir pins act SYNC_STAGES clk later.
// Backpressure: none; pause freezes the pattern while the time base keeps running.
// Ports: clk, reset (sync, active-high), pause/dir (async pins), mode, speed, load, load_data,
//        q (pattern), tick (new-value pulse), led (heartbeat), bounce_dir (1 = moving left).
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               F_CLK_HZ      = 25_000_000,
  parameter int               STEP_MS       = 500,
  parameter int               SYNC_STAGES   = 2,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             led,
  output logic             bounce_dir
);

  logic [SYNC_STAGES-1:0] pause_sr;
  logic [SYNC_STAGES-1:0] dir_sr;
  logic                   pause_s;
  logic                   dir_s;
  logic                   step_en;
  logic                   do_step;
  mode_e                  mode_c;
  logic [WIDTH-1:0]       q_step;
  logic                   bd_step;

  led_seq_tickgen #(
    .F_CLK_HZ (F_CLK_HZ),
    .STEP_MS  (STEP_MS)
  ) u_tickgen (
    .clk     (clk),
    .reset   (reset),
    .speed   (speed),
    .step_en (step_en),
    .led     (led)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pause_sr <= '0;
      dir_sr   <= '0;
    end else begin
      pause_sr[0] <= pause;
      dir_sr[0]   <= dir;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        pause_sr[i] <= pause_sr[i-1];
        dir_sr[i]   <= dir_sr[i-1];
      end
    end
  end

  assign pause_s = pause_sr[SYNC_STAGES-1];
  assign dir_s   = dir_sr[SYNC_STAGES-1];
  assign do_step = step_en && !pause_s;
  assign mode_c  = mode_e'(mode);

  // Next pattern if a step were taken this cycle.
  always_comb begin
    q_step  = q;
    bd_step = bounce_dir;
    case (mode_c)
      MODE_ROTATE: begin
        q_step = dir_s ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
      end
      MODE_BOUNCE: begin
        // Reverse at the wall and move away from it in the same step,
        // so the lit LED never dwells at an end.
        if (bounce_dir && q[WIDTH-1]) begin
          bd_step = 1'b0;
          q_step  = {1'b0, q[WIDTH-1:1]};
        end else if (!bounce_dir && q[0]) begin
          bd_step = 1'b1;
          q_step  = {q[WIDTH-2:0], 1'b0};
        end else if (bounce_dir) begin
          q_step = {q[WIDTH-2:0], 1'b0};
        end else begin
          q_step = {1'b0, q[WIDTH-1:1]};
        end
      end
      MODE_FILL: begin
        if (&q) begin
          q_step = '0;
        end else begin
          q_step = dir_s ? {q[WIDTH-2:0], 1'b1} : {1'b1, q[WIDTH-1:1]};
        end
      end
      default: begin
        q_step = q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q          <= RESET_PATTERN;
      tick       <= 1'b0;
      bounce_dir <= 1'b1;
    end else if (load) begin
      // Load swallows any coincident step: no shift and no tick.
      q          <= load_data;
      tick       <= 1'b0;
      bounce_dir <= dir_s;
    end else begin
      tick <= do_step;
      if (do_step) begin
        q <= q_step;
      end
      if (mode_c != MODE_BOUNCE) begin
        bounce_dir <= dir_s;
      end else if (do_step) begin
        bounce_dir <= bd_step;
      end
    end
  end

endmodule
